// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the four-input debounce/qualification slice.
package debounce_pkg;

  localparam int NUM_IN = 4;
  localparam int B_IDX  = 0;
  localparam int C_IDX  = 1;
  localparam int D_IDX  = 2;
  localparam int E_IDX  = 3;

  // Counter width for a given debounce length; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles) + 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One qualified line: 2-flop synchronizer, stability counter and qualified flop.
// flip_o / glitch_o are combinational flags describing what the coming edge does.
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic raw_i,
  output logic q_o,
  output logic flip_o,
  output logic glitch_o
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          qual_q, qual_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    qual_d   = qual_q;
    cnt_d    = cnt_q;
    flip_o   = 1'b0;
    glitch_o = 1'b0;
    if (en) begin
      if (s2_q != qual_q) begin
        if (cnt_q == CNT_MAX) begin
          qual_d = s2_q;
          cnt_d  = '0;
          flip_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        // Level returned before the count completed: the excursion was a glitch.
        cnt_d    = '0;
        glitch_o = (cnt_q != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      qual_q <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      qual_q <= qual_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q_o = qual_q;

endmodule

// File: rtl/debounce_qual4.sv
// Four-line input qualifier feeding b/c/d/e of the reduction block, with update strobe.
// Optional rejected-glitch counter enabled by defining DEBOUNCE_GLITCH_CNT_EN.
module debounce_qual4
  import debounce_pkg::*;
#(
  parameter int                DEBOUNCE_CYCLES = 4,
  parameter logic [NUM_IN-1:0] RST_VAL         = 4'b0000,
  parameter int                GLITCH_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_IN-1:0] raw_i,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              e,
  output logic              upd
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  logic [NUM_IN-1:0] qual;
  logic [NUM_IN-1:0] flip;
  logic [NUM_IN-1:0] glitch;
  logic              upd_q, upd_d;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_bit
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (RST_VAL[gi])
      ) u_bit (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .raw_i   (raw_i[gi]),
        .q_o     (qual[gi]),
        .flip_o  (flip[gi]),
        .glitch_o(glitch[gi])
      );
    end
  endgenerate

  assign b = qual[B_IDX];
  assign c = qual[C_IDX];
  assign d = qual[D_IDX];
  assign e = qual[E_IDX];

  // Registered alongside the qualified flops so the strobe lines up with the new level.
  always_comb begin
    upd_d = |flip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_q <= 1'b0;
    end else begin
      upd_q <= upd_d;
    end
  end

  assign upd = upd_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  localparam int                SW         = ((GLITCH_W > 3) ? GLITCH_W : 3) + 1;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

  logic [GLITCH_W-1:0] glitch_cnt_q, glitch_cnt_d;
  logic [2:0]          glitch_sum;
  logic [SW-1:0]       glitch_total;

  // Sum is formed one bit wider than either operand so saturation sees the true total.
  always_comb begin
    glitch_sum = 3'd0;
    for (int i = 0; i < NUM_IN; i++) begin
      glitch_sum = glitch_sum + {2'b00, glitch[i]};
    end
    glitch_total = SW'(glitch_cnt_q) + SW'(glitch_sum);
    if (glitch_total > SW'(GLITCH_MAX)) begin
      glitch_cnt_d = GLITCH_MAX;
    end else begin
      glitch_cnt_d = glitch_total[GLITCH_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`else
  localparam int unused_glitch_w = GLITCH_W;
  logic unused_glitch;
  assign unused_glitch = ^glitch;
`endif

endmodule

// File: tb/tb_debounce_qual4.sv
// Directed scoreboard bench for debounce_qual4 (DEBOUNCE_CYCLES=4, GLITCH_W=2).
module tb_debounce_qual4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [3:0] raw_i = 4'hF;
  logic       b, c, d, e, upd;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [1:0] glitch_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [4:0] val;   // {upd, e, d, c, b}
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  debounce_qual4 #(
    .DEBOUNCE_CYCLES(4),
    .RST_VAL        (4'b0000),
    .GLITCH_W       (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .raw_i(raw_i),
    .b    (b),
    .c    (c),
    .d    (d),
    .e    (e),
    .upd  (upd)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  function automatic logic [4:0] obs();
    return {upd, e, d, c, b};
  endfunction

  task automatic push(input string tag, input logic [4:0] v, input int n);
    exp_t x;
    x.tag = tag;
    x.val = v;
    repeat (n) sb.push_back(x);
  endtask

  task automatic cmp();
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %b required an expectation", obs());
    end else begin
      x = sb.pop_front();
      assert (obs() === x.val) else begin
        errors++;
        $error("FAIL %s observed %b required %b", x.tag, obs(), x.val);
      end
      $display("t=%0t %s out=%b exp=%b", $time, x.tag, obs(), x.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp();
    end
  endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
  task automatic gchk(input string tag, input logic [1:0] exp);
    checks++;
    assert (glitch_cnt === exp) else begin
      errors++;
      $error("FAIL %s glitch_cnt observed %0d required %0d", tag, glitch_cnt, exp);
    end
    $display("t=%0t %s glitch_cnt=%0d exp=%0d", $time, tag, glitch_cnt, exp);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with all raw lines high: nothing propagates.
    rst_n = 1'b0; raw_i = 4'hF; en = 1'b1;
    repeat (3) @(negedge clk);
    push("reset", 5'b00000, 1); cmp();
`ifdef DEBOUNCE_GLITCH_CNT_EN
    gchk("reset_glitch", 2'd0);
`endif
    raw_i = 4'h0; rst_n = 1'b1;
    push("idle", 5'b00000, 3); step(3);

    // Clean rising edge on b: 6-cycle latency, one-cycle upd.
    raw_i = 4'h1;
    push("clean_wait", 5'b00000, 5); push("clean_flip", 5'b10001, 1); push("clean_hold", 5'b00001, 1);
    step(7);

    // One-cycle pulse on d is rejected.
    raw_i = 4'h5; push("glitch1", 5'b00001, 1); step(1);
    raw_i = 4'h1; push("glitch1", 5'b00001, 6); step(6);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    gchk("glitch1_cnt", 2'd1);
`endif
    // Three-cycle pulse on d is also rejected (one short of the threshold).
    raw_i = 4'h5; push("glitch3", 5'b00001, 3); step(3);
    raw_i = 4'h1; push("glitch3", 5'b00001, 6); step(6);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    gchk("glitch3_cnt", 2'd2);
`endif

    raw_i = 4'h0;
    push("b_fall_wait", 5'b00001, 5); push("b_fall", 5'b10000, 1); push("b_fall_hold", 5'b00000, 1);
    step(7);

    // All four lines together: a single upd pulse.
    raw_i = 4'hF;
    push("all_wait", 5'b00000, 5); push("all_flip", 5'b11111, 1); push("all_hold", 5'b01111, 1);
    step(7);
    raw_i = 4'h0;
    push("all_fall_wait", 5'b01111, 5); push("all_fall", 5'b10000, 1); push("all_fall_hold", 5'b00000, 1);
    step(7);

    // b then e one cycle apart: upd high on two consecutive cycles.
    raw_i = 4'h1; push("stag_wait", 5'b00000, 1); step(1);
    raw_i = 4'h9;
    push("stag_wait", 5'b00000, 4); push("stag_b", 5'b10001, 1); push("stag_e", 5'b11001, 1);
    push("stag_hold", 5'b01001, 1);
    step(7);
    raw_i = 4'h0;
    push("stag_fall_wait", 5'b01001, 5); push("stag_fall", 5'b10000, 1); push("stag_fall_hold", 5'b00000, 1);
    step(7);

    // Enable freeze after two counted cycles; count resumes afterwards.
    raw_i = 4'h2; push("en_count", 5'b00000, 4); step(4);
    en = 1'b0;    push("en_frozen", 5'b00000, 10); step(10);
    en = 1'b1;
    push("en_resume", 5'b00000, 1); push("en_flip", 5'b10010, 1); push("en_hold", 5'b00010, 1);
    step(3);
    raw_i = 4'h0;
    push("c_fall_wait", 5'b00010, 5); push("c_fall", 5'b10000, 1); push("c_fall_hold", 5'b00000, 1);
    step(7);

    // Raise b, then assert reset mid-cycle: outputs clear without a clock edge.
    raw_i = 4'h1;
    push("pre_rst_wait", 5'b00000, 5); push("pre_rst_flip", 5'b10001, 1); push("pre_rst_hold", 5'b00001, 1);
    step(7);
    #2 rst_n = 1'b0;
    #1 push("async_rst", 5'b00000, 1); cmp();
`ifdef DEBOUNCE_GLITCH_CNT_EN
    gchk("async_rst_glitch", 2'd0);
`endif
    #1 rst_n = 1'b1;
    // Sync chain was cleared too, so the full latency applies again.
    push("post_rst_wait", 5'b00000, 5); push("post_rst_flip", 5'b10001, 1); push("post_rst_hold", 5'b00001, 1);
    step(7);
    raw_i = 4'h0;
    push("b_fall2_wait", 5'b00001, 5); push("b_fall2", 5'b10000, 1); push("b_fall2_hold", 5'b00000, 1);
    step(7);

    // Reset pulse with cnt=3 discards the count.
    raw_i = 4'h1; push("midcnt", 5'b00000, 5); step(5);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    push("midcnt_wait", 5'b00000, 5); push("midcnt_flip", 5'b10001, 1); push("midcnt_hold", 5'b00001, 1);
    step(7);
    raw_i = 4'h0;
    push("b_fall3_wait", 5'b00001, 5); push("b_fall3", 5'b10000, 1); push("b_fall3_hold", 5'b00000, 1);
    step(7);

    // Glitch counter saturation with a 2-bit counter.
    raw_i = 4'h4; push("sat_g1", 5'b00000, 1); step(1);
    raw_i = 4'h0; push("sat_g1", 5'b00000, 5); step(5);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    gchk("sat_one", 2'd1);
`endif
    raw_i = 4'h5; push("sat_g2", 5'b00000, 1); step(1);
    raw_i = 4'h0; push("sat_g2", 5'b00000, 5); step(5);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    gchk("sat_two_same_edge", 2'd3);
`endif
    for (int k = 0; k < 3; k++) begin
      raw_i = 4'h4; push("sat_more", 5'b00000, 1); step(1);
      raw_i = 4'h0; push("sat_more", 5'b00000, 5); step(5);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    gchk("sat_hold", 2'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
